// File: rtl/rv32i_processor.sv
// Two-stage RV32I core: IF fetches from IMEM, ID decodes/executes/accesses memory and
// writes back in one cycle. A taken branch or jump replaces the wrong-path fetch with a NOP.

module rv32i_imem (
  input  logic [7:0]  i_addr,
  output logic [31:0] o_data
);
  logic [31:0] imem_cell [0:255];

  assign o_data = imem_cell[i_addr];
endmodule

module rv32i_processor (
  input  logic clk,
  input  logic rst_n
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_NOP = 3'd7;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0] PC, inst, inst_ID, PC_ID, PCadd4_ID;
  logic [4:0]  i1, i2;
  logic [24:0] i3;
  logic [2:0]  type_ID, ImmSel;
  logic        PCSel, RegWEn, BrUn, BrEq, BrLT, BSel, ASel, MemRW;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;
  logic [31:0] DA, DB, imm, alu_res, memread, wb;

  logic [31:0] r_rf   [0:31];
  logic [31:0] r_dmem [0:255];

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_funct7b5, w_jump, w_branch, w_br_taken;
  logic [3:0]  w_alu_f;
  logic [31:0] w_pc_add4, w_a, w_b, w_alu_raw;

  rv32i_imem IMEM (
    .i_addr (PC[9:2]),
    .o_data (inst)
  );

  assign w_pc_add4  = PC + 32'd4;
  assign i1         = inst_ID[19:15];
  assign i2         = inst_ID[24:20];
  assign i3         = inst_ID[31:7];
  assign w_opcode   = inst_ID[6:0];
  assign w_funct3   = inst_ID[14:12];
  assign w_rd       = inst_ID[11:7];
  assign w_funct7b5 = inst_ID[30];

  // Fetch PC and IF/ID register; a redirect squashes the wrong-path fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC        <= 32'd0;
      inst_ID   <= NOP_INST;
      PC_ID     <= 32'd0;
      PCadd4_ID <= 32'd0;
    end else if (PCSel) begin
      PC        <= alu_res;
      inst_ID   <= NOP_INST;
      PC_ID     <= 32'd0;
      PCadd4_ID <= 32'd0;
    end else begin
      PC        <= w_pc_add4;
      inst_ID   <= inst;
      PC_ID     <= PC;
      PCadd4_ID <= w_pc_add4;
    end
  end

  // Instruction format classification
  always_comb begin
    type_ID = T_NOP;
    case (w_opcode)
      OP_R:                      type_ID = T_R;
      OP_IMM, OP_LOAD, OP_JALR:  type_ID = T_I;
      OP_STORE:                  type_ID = T_S;
      OP_BRANCH:                 type_ID = T_B;
      OP_LUI, OP_AUIPC:          type_ID = T_U;
      OP_JAL:                    type_ID = T_J;
      default:                   type_ID = T_NOP;
    endcase
  end

  assign ImmSel = type_ID;

  // Immediate generation; i3 holds instruction bits [31:7], so bit n sits at i3[n-7]
  always_comb begin
    imm = 32'd0;
    case (ImmSel)
      T_I:     imm = {{20{i3[24]}}, i3[24:13]};
      T_S:     imm = {{20{i3[24]}}, i3[24:18], i3[4:0]};
      T_B:     imm = {{19{i3[24]}}, i3[24], i3[0], i3[23:18], i3[4:1], 1'b0};
      T_U:     imm = {i3[24:5], 12'd0};
      T_J:     imm = {{11{i3[24]}}, i3[24], i3[12:5], i3[13], i3[23:14], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  assign DA = (i1 == 5'd0) ? 32'd0 : r_rf[i1];
  assign DB = (i2 == 5'd0) ? 32'd0 : r_rf[i2];

  // ALU op from funct3; funct7[5] only means SUB for register-register ops
  always_comb begin
    w_alu_f = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_f = (w_opcode == OP_R && w_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_f = ALU_SLL;
      3'b010:  w_alu_f = ALU_SLT;
      3'b011:  w_alu_f = ALU_SLTU;
      3'b100:  w_alu_f = ALU_XOR;
      3'b101:  w_alu_f = w_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_f = ALU_OR;
      3'b111:  w_alu_f = ALU_AND;
      default: w_alu_f = ALU_ADD;
    endcase
  end

  // Main control; unsupported opcodes fall through with no side effects
  always_comb begin
    RegWEn   = 1'b0;
    MemRW    = 1'b0;
    ASel     = 1'b0;
    BSel     = 1'b1;
    WBSel    = WB_ALU;
    ALUSel   = ALU_ADD;
    w_jump   = 1'b0;
    w_branch = 1'b0;
    case (w_opcode)
      OP_R:      begin RegWEn = 1'b1; BSel = 1'b0; ALUSel = w_alu_f; end
      OP_IMM:    begin RegWEn = 1'b1; ALUSel = w_alu_f; end
      OP_LOAD:   begin RegWEn = 1'b1; WBSel = WB_MEM; end
      OP_JALR:   begin RegWEn = 1'b1; WBSel = WB_PC4; w_jump = 1'b1; end
      OP_STORE:  begin MemRW = 1'b1; end
      OP_BRANCH: begin ASel = 1'b1; w_branch = 1'b1; end
      OP_LUI:    begin RegWEn = 1'b1; ALUSel = ALU_PASSB; end
      OP_AUIPC:  begin RegWEn = 1'b1; ASel = 1'b1; end
      OP_JAL:    begin RegWEn = 1'b1; ASel = 1'b1; WBSel = WB_PC4; w_jump = 1'b1; end
      default:   begin BSel = 1'b0; end
    endcase
  end

  // Branch comparator and condition select
  always_comb begin
    BrUn = w_branch && (w_funct3[2:1] == 2'b11);
    BrEq = (DA == DB);
    BrLT = BrUn ? (DA < DB) : ($signed(DA) < $signed(DB));
    case (w_funct3)
      3'b000:  w_br_taken = BrEq;
      3'b001:  w_br_taken = !BrEq;
      3'b100:  w_br_taken = BrLT;
      3'b101:  w_br_taken = !BrLT;
      3'b110:  w_br_taken = BrLT;
      3'b111:  w_br_taken = !BrLT;
      default: w_br_taken = 1'b0;
    endcase
  end

  assign PCSel = w_jump || (w_branch && w_br_taken);
  assign w_a   = ASel ? PC_ID : DA;
  assign w_b   = BSel ? imm : DB;

  // ALU
  always_comb begin
    w_alu_raw = 32'd0;
    case (ALUSel)
      ALU_ADD:   w_alu_raw = w_a + w_b;
      ALU_SUB:   w_alu_raw = w_a - w_b;
      ALU_SLL:   w_alu_raw = w_a << w_b[4:0];
      ALU_SLT:   w_alu_raw = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU:  w_alu_raw = {31'd0, w_a < w_b};
      ALU_XOR:   w_alu_raw = w_a ^ w_b;
      ALU_SRL:   w_alu_raw = w_a >> w_b[4:0];
      ALU_SRA:   w_alu_raw = $signed(w_a) >>> w_b[4:0];
      ALU_OR:    w_alu_raw = w_a | w_b;
      ALU_AND:   w_alu_raw = w_a & w_b;
      ALU_PASSB: w_alu_raw = w_b;
      default:   w_alu_raw = w_a + w_b;
    endcase
  end

  assign alu_res = (w_opcode == OP_JALR) ? (w_alu_raw & ~32'd1) : w_alu_raw;
  assign memread = r_dmem[alu_res[9:2]];

  // Writeback source select
  always_comb begin
    case (WBSel)
      WB_MEM:  wb = memread;
      WB_ALU:  wb = alu_res;
      WB_PC4:  wb = PCadd4_ID;
      default: wb = alu_res;
    endcase
  end

  // Register file; x0 is never written so it stays zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) r_rf[k] <= 32'd0;
    end else if (RegWEn && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= wb;
    end
  end

  // Data memory keeps its contents through reset; a held reset forces a NOP so MemRW is low
  always_ff @(posedge clk) begin
    if (MemRW) r_dmem[alu_res[9:2]] <= DB;
  end
endmodule

// File: tb/tb_rv32i_processor.sv
// Bench for rv32i_processor: directed program checks plus random programs run against an
// instruction-level model that steps one architectural instruction at a time.

module tb_rv32i_processor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rv32i_processor dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_SLT = 3, K_SLTU = 4, K_XOR = 5,
                 K_SRL = 6, K_SRA = 7, K_OR = 8, K_AND = 9,
                 K_ADDI = 10, K_SLTI = 11, K_SLTIU = 12, K_XORI = 13, K_ORI = 14,
                 K_ANDI = 15, K_SLLI = 16, K_SRLI = 17, K_SRAI = 18,
                 K_LUI = 19, K_AUIPC = 20, K_LW = 21, K_SW = 22,
                 K_BEQ = 23, K_BNE = 24, K_BLT = 25, K_BGE = 26, K_BLTU = 27, K_BGEU = 28,
                 K_JAL = 29, K_JALR = 30, K_ECALL = 31, K_FENCE = 32;

  int          n_checks = 0;
  int          n_fail = 0;
  int          p_n;
  int          p_k [256];
  int          p_rd [256];
  int          p_rs1 [256];
  int          p_rs2 [256];
  logic [31:0] p_imm [256];
  logic [31:0] p_word [256];
  logic [31:0] end_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] enc(input int k, input int rd, input int rs1, input int rs2,
                                      input logic [31:0] im);
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [6:0] f7;
    d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    f7 = (k == K_SUB || k == K_SRA || k == K_SRAI) ? 7'h20 : 7'h00;
    case (k)
      K_ADD, K_SUB, K_ADDI, K_BEQ:  f3 = 3'd0;
      K_SLL, K_SLLI, K_BNE:         f3 = 3'd1;
      K_SLT, K_SLTI:                f3 = 3'd2;
      K_SLTU, K_SLTIU:              f3 = 3'd3;
      K_XOR, K_XORI, K_BLT:         f3 = 3'd4;
      K_SRL, K_SRA, K_SRLI, K_SRAI, K_BGE: f3 = 3'd5;
      K_OR, K_ORI, K_BLTU:          f3 = 3'd6;
      default:                      f3 = 3'd7;
    endcase
    if (k <= K_AND) return {f7, s2, s1, f3, d, 7'h33};
    if (k >= K_SLLI && k <= K_SRAI) return {f7, im[4:0], s1, f3, d, 7'h13};
    if (k <= K_ANDI) return {im[11:0], s1, f3, d, 7'h13};
    case (k)
      K_LUI:   return {im[31:12], d, 7'h37};
      K_AUIPC: return {im[31:12], d, 7'h17};
      K_LW:    return {im[11:0], s1, 3'b010, d, 7'h03};
      K_SW:    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
      K_JALR:  return {im[11:0], s1, 3'b000, d, 7'h67};
      K_ECALL: return 32'h0000_0073;
      K_FENCE: return 32'h0FF0_000F;
      default: return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
    endcase
  endfunction

  task automatic clear_prog();
    p_n = 0;
    for (int i = 0; i < 256; i++) begin
      p_word[i] = 32'h0000_0013; p_k[i] = K_ECALL;
      p_rd[i] = 0; p_rs1[i] = 0; p_rs2[i] = 0; p_imm[i] = 32'd0;
    end
  endtask

  task automatic emit(input int k, input int rd, input int rs1, input int rs2, input logic [31:0] im);
    p_k[p_n] = k; p_rd[p_n] = rd; p_rs1[p_n] = rs1; p_rs2[p_n] = rs2; p_imm[p_n] = im;
    p_word[p_n] = enc(k, rd, rs1, rs2, im);
    p_n++;
    end_pc = 32'(4 * (p_n - 1));
  endtask

  task automatic rnd_alu();
    int k;
    logic [31:0] r;
    k = $urandom_range(K_ADD, K_AUIPC);
    r = $urandom;
    if (k >= K_SLLI && k <= K_SRAI) r = {27'd0, r[4:0]};
    else if (k >= K_LUI) r = r & 32'hFFFF_F000;
    else r = sx12(r[11:0]);
    emit(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), r);
  endtask

  // Architectural step of the instruction at m_pc; returns redirect, written rd, stored word
  task automatic exec(output logic taken, output int wrd, output int sidx);
    int i, k;
    logic [31:0] a, b, im, res, addr, npc;
    logic wr;
    i = int'(m_pc[9:2]); k = p_k[i];
    a = m_reg[p_rs1[i]]; b = m_reg[p_rs2[i]]; im = p_imm[i];
    taken = 1'b0; wr = 1'b1; sidx = -1; npc = m_pc + 32'd4; res = 32'd0; addr = a + im;
    case (k)
      K_ADD:   res = a + b;
      K_SUB:   res = a - b;
      K_SLL:   res = a << b[4:0];
      K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      K_XOR:   res = a ^ b;
      K_SRL:   res = a >> b[4:0];
      K_SRA:   res = $signed(a) >>> b[4:0];
      K_OR:    res = a | b;
      K_AND:   res = a & b;
      K_ADDI:  res = a + im;
      K_SLTI:  res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
      K_SLTIU: res = (a < im) ? 32'd1 : 32'd0;
      K_XORI:  res = a ^ im;
      K_ORI:   res = a | im;
      K_ANDI:  res = a & im;
      K_SLLI:  res = a << im[4:0];
      K_SRLI:  res = a >> im[4:0];
      K_SRAI:  res = $signed(a) >>> im[4:0];
      K_LUI:   res = im;
      K_AUIPC: res = m_pc + im;
      K_LW:    res = m_mem[addr[9:2]];
      K_SW:    begin m_mem[addr[9:2]] = b; sidx = int'(addr[9:2]); wr = 1'b0; end
      K_BEQ:   begin wr = 1'b0; taken = (a == b); end
      K_BNE:   begin wr = 1'b0; taken = (a != b); end
      K_BLT:   begin wr = 1'b0; taken = ($signed(a) < $signed(b)); end
      K_BGE:   begin wr = 1'b0; taken = ($signed(a) >= $signed(b)); end
      K_BLTU:  begin wr = 1'b0; taken = (a < b); end
      K_BGEU:  begin wr = 1'b0; taken = (a >= b); end
      K_JAL:   begin res = m_pc + 32'd4; npc = m_pc + im; taken = 1'b1; end
      K_JALR:  begin res = m_pc + 32'd4; npc = (a + im) & ~32'd1; taken = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (taken && k >= K_BEQ && k <= K_BGEU) npc = m_pc + im;
    wrd = (wr && p_rd[i] != 0) ? p_rd[i] : 0;
    if (wrd != 0) m_reg[wrd] = res;
    m_pc = npc;
  endtask

  task automatic reset_and_load();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) dut.IMEM.imem_cell[i] = p_word[i];
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clk);
    chk("rst_pc", dut.PC, 32'd0);
    chk("rst_inst_id", dut.inst_ID, 32'h0000_0013);
    chk("rst_pc_id", dut.PC_ID, 32'd0);
    chk("rst_pcadd4_id", dut.PCadd4_ID, 32'd0);
    chk("rst_x1", dut.r_rf[1], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_prog(input int max_steps);
    int steps, wrd, sidx;
    logic taken;
    reset_and_load();
    steps = 0;
    while (m_pc != end_pc && steps < max_steps) begin
      chk("pc_id", dut.PC_ID, m_pc);
      chk("inst_id", dut.inst_ID, p_word[m_pc[9:2]]);
      exec(taken, wrd, sidx);
      @(negedge clk);
      if (wrd != 0) chk("wb_rd", dut.r_rf[wrd], m_reg[wrd]);
      if (sidx >= 0) chk("st_mem", dut.r_dmem[sidx], m_mem[sidx]);
      if (taken) begin
        chk("bubble_inst", dut.inst_ID, 32'h0000_0013);
        chk("bubble_pc_id", dut.PC_ID, 32'd0);
        @(negedge clk);
      end
      steps++;
    end
    chk("end_pc_id", dut.PC_ID, end_pc);
    for (int r = 0; r < 32; r++) chk("final_reg", dut.r_rf[r], m_reg[r]);
  endtask

  initial begin
    // Directed: addi/addi/add/sw/lw
    clear_prog();
    emit(K_ADDI, 1, 0, 0, 32'd5);
    emit(K_ADDI, 2, 0, 0, 32'd7);
    emit(K_ADD, 3, 1, 2, 32'd0);
    emit(K_SW, 0, 0, 3, 32'd0);
    emit(K_LW, 4, 0, 0, 32'd0);
    emit(K_JAL, 0, 0, 0, 32'd0);
    reset_and_load();
    chk("a_inst_id", dut.inst_ID, 32'h0050_0093);
    chk("a_pc_id", dut.PC_ID, 32'd0);
    chk("a_i1", 32'(dut.i1), 32'd0);
    chk("a_i3", 32'(dut.i3), 32'h000_A001);
    chk("a_type", 32'(dut.type_ID), 32'd1);
    chk("a_immsel", 32'(dut.ImmSel), 32'd1);
    chk("a_pcadd4", dut.PCadd4_ID, 32'd4);
    @(negedge clk);
    chk("a_x1", dut.r_rf[1], 32'd5);
    @(negedge clk);
    chk("a_add_inst", dut.inst_ID, 32'h0020_81B3);
    chk("a_add_type", 32'(dut.type_ID), 32'd0);
    chk("a_add_i1", 32'(dut.i1), 32'd1);
    chk("a_add_i2", 32'(dut.i2), 32'd2);
    @(negedge clk);
    chk("a_x3", dut.r_rf[3], 32'h0000_000C);
    chk("a_sw_inst", dut.inst_ID, 32'h0030_2023);
    chk("a_sw_type", 32'(dut.type_ID), 32'd2);
    chk("a_sw_memrw", 32'(dut.MemRW), 32'd1);
    @(negedge clk);
    chk("a_dmem0", dut.r_dmem[0], 32'h0000_000C);
    chk("a_lw_inst", dut.inst_ID, 32'h0000_2203);
    @(negedge clk);
    chk("a_x4", dut.r_rf[4], 32'h0000_000C);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", dut.PC, 32'd0);
    chk("mid_rst_inst_id", dut.inst_ID, 32'h0000_0013);
    chk("mid_rst_x3", dut.r_rf[3], 32'd0);

    // Directed: taken beq skips address 4
    clear_prog();
    emit(K_BEQ, 0, 0, 0, 32'd8);
    emit(K_ADDI, 5, 0, 0, 32'd1);
    emit(K_JAL, 0, 0, 0, 32'd0);
    chk("b_word", p_word[0], 32'h0000_0463);
    run_prog(10);

    // Directed: jal links PC+4
    clear_prog();
    emit(K_JAL, 1, 0, 0, 32'd8);
    emit(K_ADDI, 5, 0, 0, 32'd1);
    emit(K_JAL, 0, 0, 0, 32'd0);
    run_prog(10);
    chk("c_jal_link", dut.r_rf[1], 32'd4);

    // Random programs: ALU warm-up, fill words 0..15, then a mixed forward-only body
    for (int prog = 0; prog < 4; prog++) begin
      clear_prog();
      repeat (20) rnd_alu();
      for (int w = 0; w < 16; w++)
        emit(K_SW, 0, 0, $urandom_range(1, 31), 32'(4 * w + 1024 * $urandom_range(0, 1)));
      repeat (60) begin
        case ($urandom_range(0, 9))
          4: emit(K_LW, $urandom_range(0, 31), 0, 0,
                  32'(4 * $urandom_range(0, 15) + 1024 * $urandom_range(0, 1)));
          5: emit(K_SW, 0, 0, $urandom_range(0, 31), 32'(4 * $urandom_range(0, 15)));
          6: emit($urandom_range(K_BEQ, K_BGEU), 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  32'(4 * $urandom_range(1, 3)));
          7: emit(K_JAL, $urandom_range(0, 31), 0, 0, 32'(4 * $urandom_range(1, 3)));
          8: emit(K_JALR, $urandom_range(0, 31), 0, 0, 32'(4 * (p_n + $urandom_range(1, 3)) + 1));
          9: emit($urandom_range(K_ECALL, K_FENCE), 0, 0, 0, 32'd0);
          default: rnd_alu();
        endcase
      end
      repeat (3) rnd_alu();
      emit(K_JAL, 0, 0, 0, 32'd0);
      run_prog(200);
      for (int w = 0; w < 16; w++) chk("final_mem", dut.r_dmem[w], m_mem[w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
